// File: rtl/div32_pkg.sv
// Shared types and sizing constants for the sequential divider.
`timescale 1ns/1ps
package div32_pkg;

   localparam int unsigned WIDTH_DEF = 32;
   localparam int unsigned CNT_W     = $clog2(WIDTH_DEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/div32_step.sv
// One restoring-division step: shift in the next dividend bit, trial subtract, select.
`timescale 1ns/1ps
module div32_step
   import div32_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next_c,
   output logic             q_bit_c
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   assign shifted    = {rem, bit_in};
   assign diff       = shifted - {1'b0, divisor};
   // Non-negative trial result means the divisor fits: keep the difference.
   assign q_bit_c    = ~diff[WIDTH];
   assign rem_next_c = q_bit_c ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div32_seq.sv
// Sequential restoring divider, one quotient bit per cycle.
// Define DIV32_SIGNED_EN to add the sgn port and two's-complement operation.
`timescale 1ns/1ps
module div32_seq
   import div32_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
`ifdef DIV32_SIGNED_EN
   input  logic             sgn,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             dz
);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] quo, quo_nxt;
   logic [WIDTH-1:0] rem, rem_nxt;
   logic [WIDTH-1:0] dvs, dvs_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             neg_q, neg_q_nxt;
   logic             neg_r, neg_r_nxt;
   logic             done_nxt, dz_nxt;
   logic [WIDTH-1:0] q_nxt, r_nxt;
   logic [WIDTH-1:0] step_rem_c;
   logic             q_bit_c;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   // Operand sign handling; the core always divides magnitudes.
`ifdef DIV32_SIGNED_EN
   assign a_neg = sgn & A[WIDTH-1];
   assign b_neg = sgn & B[WIDTH-1];
`else
   assign a_neg = 1'b0;
   assign b_neg = 1'b0;
`endif
   assign a_mag = a_neg ? -A : A;
   assign b_mag = b_neg ? -B : B;

   div32_step #(.WIDTH(WIDTH)) u_step (
      .rem        (rem),
      .bit_in     (quo[WIDTH-1]),
      .divisor    (dvs),
      .rem_next_c (step_rem_c),
      .q_bit_c    (q_bit_c)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_nxt = state;
      quo_nxt   = quo;
      rem_nxt   = rem;
      dvs_nxt   = dvs;
      cnt_nxt   = cnt;
      neg_q_nxt = neg_q;
      neg_r_nxt = neg_r;
      done_nxt  = 1'b0;
      dz_nxt    = dz;
      q_nxt     = Q;
      r_nxt     = R;
      case (state)
         IDLE: begin
            if (start) begin
               if (B == '0) begin
                  state_nxt = DONE;
                  done_nxt  = 1'b1;
                  dz_nxt    = 1'b1;
                  q_nxt     = '1;
                  r_nxt     = A;
               end else begin
                  state_nxt = RUN;
                  dz_nxt    = 1'b0;
                  quo_nxt   = a_mag;
                  rem_nxt   = '0;
                  dvs_nxt   = b_mag;
                  cnt_nxt   = '0;
                  neg_q_nxt = a_neg ^ b_neg;
                  neg_r_nxt = a_neg;
               end
            end
         end
         RUN: begin
            quo_nxt = {quo[WIDTH-2:0], q_bit_c};
            rem_nxt = step_rem_c;
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
               state_nxt = DONE;
               done_nxt  = 1'b1;
               q_nxt     = neg_q ? -quo_nxt : quo_nxt;
               r_nxt     = neg_r ? -rem_nxt : rem_nxt;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         quo   <= '0;
         rem   <= '0;
         dvs   <= '0;
         cnt   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         dz    <= 1'b0;
         Q     <= '0;
         R     <= '0;
      end else begin
         state <= state_nxt;
         quo   <= quo_nxt;
         rem   <= rem_nxt;
         dvs   <= dvs_nxt;
         cnt   <= cnt_nxt;
         neg_q <= neg_q_nxt;
         neg_r <= neg_r_nxt;
         busy  <= (state_nxt != IDLE);
         done  <= done_nxt;
         dz    <= dz_nxt;
         Q     <= q_nxt;
         R     <= r_nxt;
      end
   end

endmodule

// File: tb/tb_div32_seq.sv
// Scoreboard bench for div32_seq: directed corner cases plus randomized operands.
`timescale 1ns/1ps
module tb_div32_seq;

   localparam time T    = 10;
   localparam time HALF = 5;

`ifdef DIV32_SIGNED_EN
   localparam bit SGN_EN = 1'b1;
`else
   localparam bit SGN_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
      time         t;
   } resp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        sgn = 1'b0;
   logic        busy, done, dz;
   logic [31:0] Q, R;

   int checks = 0;
   int errors = 0;
   int cyc_i  = 0;
   resp_t sb[$];

   always #(HALF) clk = ~clk;

   div32_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
`ifdef DIV32_SIGNED_EN
      .sgn   (sgn),
`endif
      .busy  (busy),
      .done  (done),
      .Q     (Q),
      .R     (R),
      .dz    (dz)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: plain integer division semantics, truncating toward zero.
   function automatic resp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
      resp_t e;
      int    sa, sb_i;
      e.t  = 0;
      e.dz = 1'b0;
      if (b == 32'd0) begin
         e.q  = 32'hFFFF_FFFF;
         e.r  = a;
         e.dz = 1'b1;
      end else if (!s) begin
         e.q = a / b;
         e.r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.q = 32'h8000_0000;
         e.r = 32'd0;
      end else begin
         sa   = $signed(a);
         sb_i = $signed(b);
         e.q  = 32'(sa / sb_i);
         e.r  = 32'(sa % sb_i);
      end
      return e;
   endfunction

   // Drive one start at the current negedge; leaves the bench at cycle 1.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
      resp_t e;
      e   = model(a, b, s);
      e.t = $time + HALF + ((b == 32'd0) ? 0 : 32) * T;
      sb.push_back(e);
      A     = a;
      B     = b;
      sgn   = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      A     = $urandom;
      B     = $urandom;
      sgn   = SGN_EN & 1'($urandom);
      cyc_i = 1;
   endtask

   task automatic to_cycle(input int k);
      repeat (k - cyc_i) @(negedge clk);
      cyc_i = k;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("idle_timeout", 64'(busy), 64'd0);
   endtask

   // Monitor: every done pulse is matched against the oldest expectation.
   initial begin
      resp_t e;
      logic  prev_done;
      prev_done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (done) begin
            if (prev_done) chk("done_width", 64'(prev_done), 64'd0);
            if (sb.size() == 0) begin
               chk("unexpected_done", 64'(done), 64'd0);
            end else begin
               e = sb.pop_front();
               chk("done_time", 64'($time - 1), 64'(e.t));
               chk("Q", 64'(Q), 64'(e.q));
               chk("R", 64'(R), 64'(e.r));
               chk("dz", 64'(dz), 64'(e.dz));
            end
         end
         prev_done = done;
      end
   end

   initial begin
      logic        busy_ok;
      logic [31:0] ra, rb;
      int          sel;

      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_Q", 64'(Q), 64'd0);
      chk("rst_R", 64'(R), 64'd0);
      chk("rst_dz", 64'(dz), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 100 / 7 with busy window and result hold.
      issue(32'd100, 32'd7, 1'b0);
      busy_ok = 1'b1;
      for (int k = 1; k <= 33; k++) begin
         if (!busy) busy_ok = 1'b0;
         @(negedge clk);
      end
      cyc_i = 34;
      chk("busy_window", 64'(busy_ok), 64'd1);
      chk("busy_after", 64'(busy), 64'd0);
      chk("hold_Q", 64'(Q), 64'd14);
      chk("hold_R", 64'(R), 64'd2);

      issue(32'hFFFF_FFFF, 32'd1, 1'b0); wait_idle();
      issue(32'd5, 32'd9, 1'b0);         wait_idle();
      issue(32'd1234, 32'd0, 1'b0);      wait_idle();
      chk("dz_hold", 64'(dz), 64'd1);
      issue(32'd10, 32'd3, 1'b0);        wait_idle();

      // Starts while busy are ignored; start on return to IDLE is accepted.
      issue(32'd1000, 32'd33, 1'b0);
      to_cycle(5);
      A = 32'd77; B = 32'd0; start = 1'b1;
      to_cycle(6);
      start = 1'b0;
      to_cycle(20);
      A = 32'd9; B = 32'd2; start = 1'b1;
      to_cycle(21);
      start = 1'b0;
      to_cycle(34);
      issue(32'd4000, 32'd9, 1'b0);
      wait_idle();

      // Asynchronous reset in the middle of a run.
      issue(32'd999, 32'd4, 1'b0);
      to_cycle(15);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_done", 64'(done), 64'd0);
      chk("mid_rst_Q", 64'(Q), 64'd0);
      chk("mid_rst_R", 64'(R), 64'd0);
      chk("mid_rst_dz", 64'(dz), 64'd0);
      void'(sb.pop_back());
      @(negedge clk);
      rst_n = 1'b1;
      issue(32'd999, 32'd4, 1'b0);
      wait_idle();

      // Signed corner cases.
      if (SGN_EN) begin
         issue(32'hFFFF_FFF9, 32'd2, 1'b1);         wait_idle();
         chk("sgn_Q", 64'(Q), 64'hFFFF_FFFD);
         chk("sgn_R", 64'(R), 64'hFFFF_FFFF);
         issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_idle();
         issue(32'hFFFF_FF00, 32'd0, 1'b1);         wait_idle();
      end

      // Randomized operands, including zero and small divisors and A<B.
      for (int i = 0; i < 30; i++) begin
         sel = $urandom_range(0, 9);
         ra  = $urandom;
         case (sel)
            0:       rb = 32'd0;
            1, 2, 3: rb = 32'($urandom_range(1, 15));
            4:       begin ra = 32'($urandom_range(0, 1000)); rb = ra + 32'($urandom_range(1, 50)); end
            default: rb = $urandom;
         endcase
         issue(ra, rb, SGN_EN & 1'($urandom));
         wait_idle();
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      chk("drain", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/div32_seq.md
DIV32_SEQ -- requirements
Module: div32_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1: request a division; sampled only in IDLE.
REQ-005 SHALL have port A, input, WIDTH: dividend; captured on the accepted start.
REQ-006 SHALL have port B, input, WIDTH: divisor; captured on the accepted start.
REQ-007 SHALL have port busy, output, 1: high while a division is in progress.
REQ-008 SHALL have port done, output, 1: one-cycle pulse when Q and R become valid.
REQ-009 SHALL have port Q, output, WIDTH: quotient.
REQ-010 SHALL have port R, output, WIDTH: remainder.
REQ-011 SHALL have port dz, output, 1: divide-by-zero flag for the last result.

Function
REQ-012 SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-013 SHALL move IDLE->RUN when start=1 in IDLE and B!=0, capturing A and B; this edge is cycle 0.
REQ-014 SHALL run restoring division MSB-first, one quotient bit per cycle, for exactly WIDTH cycles in RUN (cycles 1..32).
REQ-015 SHALL use a WIDTH+1-bit trial subtract (partial remainder minus divisor) per step; quotient bit = 1 and remainder updates when the result is non-negative.
REQ-016 SHALL enter DONE after the last RUN cycle, assert done for exactly that one cycle (cycle 33), then return to IDLE.
REQ-017 SHALL hold Q, R and dz stable from done until the next accepted start.
REQ-018 SHALL keep busy=1 in RUN and DONE, and busy=0 in IDLE.
REQ-019 SHALL ignore start while busy=1; captured operands and the result are unaffected.
REQ-020 SHALL, on start with B==0, go IDLE->DONE in one cycle with Q=all ones, R=A, dz=1 and done at cycle 1.
REQ-021 SHALL clear dz on every accepted start with B!=0.
REQ-022 SHALL accept start in the same cycle that returns to IDLE after DONE, so back-to-back results are 34 cycles apart.
REQ-023 SHALL produce Q=0 and R=A when A<B, still taking the full WIDTH cycles.

Reset
REQ-024 SHALL, on rst_n=0 at any time, go to IDLE with busy=0, done=0, Q=0, R=0, dz=0 and all internal registers cleared.
REQ-025 SHALL abandon any division in progress on reset mid-operation; no done pulse is produced for it.
REQ-026 SHALL accept a start on the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL use macro DIV32_SIGNED_EN to compile signed support in or out.
REQ-028 SHALL, with DIV32_SIGNED_EN defined, add input port sgn (1 bit, sampled with start) and treat A and B as two's complement when sgn=1.
REQ-029 SHALL, in signed mode, divide magnitudes; Q is negated when sign(A)!=sign(B); R takes the sign of A.
REQ-030 SHALL, in signed mode, return Q=32'h80000000, R=0 for -2^31 / -1.
REQ-031 SHALL, in signed mode, keep divide-by-zero behaviour as REQ-020, with R=A unmodified.
REQ-032 SHALL, without DIV32_SIGNED_EN, have no sgn port and perform unsigned division only; latency is identical in both builds.

Structure
REQ-033 SHALL place the state type (IDLE/RUN/DONE), the WIDTH default and the iteration-count width constant in shared package div32_pkg.
REQ-034 SHALL implement one division step (trial subtract, quotient bit, next remainder) as combinational sub-module div32_step, instantiated once.

Verification
REQ-035 SHALL test A=100, B=7, start pulse: done at cycle 33, Q=14, R=2, dz=0, busy=1 for cycles 1..33.
REQ-036 SHALL test A=32'hFFFFFFFF, B=1: Q=32'hFFFFFFFF, R=0; then A=5, B=9: Q=0, R=5.
REQ-037 SHALL test A=1234, B=0: done at cycle 1, Q=32'hFFFFFFFF, R=1234, dz=1; then A=10, B=3 gives Q=3, R=1, dz=0.
REQ-038 SHALL test start pulses at cycles 5 and 20 with new operands during a run: both ignored, first result unchanged; start on the return to IDLE is accepted.
REQ-039 SHALL test rst_n low at cycle 15 of a run: all outputs 0 asynchronously, no done pulse; next division correct.
REQ-040 SHALL test, with DIV32_SIGNED_EN and sgn=1: -7/2 gives Q=-3, R=-1; 32'h80000000 / -1 gives Q=32'h80000000, R=0.
